// File: rtl/program_memory_if.sv
// Fetch and loader signal bundle for program_memory.
// The memory block uses the slave modport; the CPU/loader side uses master.
interface program_memory_if #(
    parameter int NB_ADDR   = 11,
    parameter int RAM_WIDTH = 16
);
    logic [NB_ADDR-1:0]   i_addr;
    logic [RAM_WIDTH-1:0] o_instruction;
    logic                 i_load_valid;
    logic [7:0]           i_load_byte;
    logic                 o_load_ready;
    logic                 i_reload;
    logic                 o_cpu_en;
    logic [NB_ADDR:0]     o_words;
    logic [7:0]           o_checksum;

    modport slave (
        input  i_addr, i_load_valid, i_load_byte, i_reload,
        output o_instruction, o_load_ready, o_cpu_en, o_words, o_checksum
    );

    modport master (
        output i_addr, i_load_valid, i_load_byte, i_reload,
        input  o_instruction, o_load_ready, o_cpu_en, o_words, o_checksum
    );
endinterface

// File: rtl/program_memory.sv
// Program memory with a byte-serial loader.
// Bytes arrive high-first and are packed into words at an incrementing
// pointer until a HALT opcode (0) or the last address is written; the block
// then switches to RUN and serves 1-cycle-latency fetches to the CPU.
// Optional feature macro: PM_CHECKSUM_EN (modulo-256 sum of loaded bytes).
module program_memory #(
    parameter int NB_ADDR   = 11,
    parameter int RAM_WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    program_memory_if.slave    bus
);
    localparam int DEPTH = 2 ** NB_ADDR;

    typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;

    state_t               state_q, state_d;
    logic [NB_ADDR:0]     wptr_q, wptr_d;
    logic [7:0]           hi_q, hi_d;
    logic [RAM_WIDTH-1:0] instr_q, instr_d;

    // Contents are never reset: reload/reset must leave old words in place.
    logic [RAM_WIDTH-1:0] mem [DEPTH];

    logic                 load_ready;
    logic                 cpu_en;
    logic                 accept;
    logic                 reload_go;
    logic                 mem_we;
    logic                 halt_op;
    logic                 last_addr;
    logic [RAM_WIDTH-1:0] word;

    assign word      = RAM_WIDTH'({hi_q, bus.i_load_byte});
    assign halt_op   = (word[RAM_WIDTH-1 -: 5] == 5'd0);
    assign last_addr = (wptr_q[NB_ADDR-1:0] == {NB_ADDR{1'b1}});

    // State register with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) state_q <= LOAD_HI;
        else        state_q <= state_d;
    end

    // Next-state logic: loader steps on strobes, RUN leaves only on reload
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD_HI: if (bus.i_load_valid) state_d = LOAD_LO;
            LOAD_LO: if (bus.i_load_valid) state_d = (halt_op || last_addr) ? RUN : LOAD_HI;
            RUN:     if (bus.i_reload)     state_d = LOAD_HI;
            default: state_d = LOAD_HI;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        load_ready = (state_q != RUN);
        cpu_en     = (state_q == RUN);
        accept     = load_ready && bus.i_load_valid;
        reload_go  = cpu_en && bus.i_reload;
    end

    // Datapath next values: high-byte latch, write pointer, fetch register
    always_comb begin
        hi_d    = hi_q;
        wptr_d  = wptr_q;
        // A reset edge must not commit a word built from the pending high byte.
        mem_we  = (state_q == LOAD_LO) && bus.i_load_valid && i_rst;
        instr_d = (state_q == RUN) ? mem[bus.i_addr] : '0;
        if (state_q == LOAD_HI && bus.i_load_valid) hi_d = bus.i_load_byte;
        // The pointer doubles as the word count; RUN is entered at the last
        // address so it tops out at DEPTH and never wraps.
        if (reload_go)   wptr_d = '0;
        else if (mem_we) wptr_d = wptr_q + 1'b1;
    end

    // Datapath registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            hi_q    <= '0;
            wptr_q  <= '0;
            instr_q <= '0;
        end else begin
            hi_q    <= hi_d;
            wptr_q  <= wptr_d;
            instr_q <= instr_d;
        end
    end

    // Word write on LOAD_LO acceptance
    always_ff @(posedge i_clk) begin
        if (mem_we) mem[wptr_q[NB_ADDR-1:0]] <= word;
    end

`ifdef PM_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Checksum accumulates accepted bytes; reload from RUN restarts it
    always_comb begin
        csum_d = csum_q;
        if (reload_go)   csum_d = '0;
        else if (accept) csum_d = csum_q + bus.i_load_byte;
    end

    // Checksum register with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_rst) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign bus.o_checksum = csum_q;
`else
    assign bus.o_checksum = 8'd0;
`endif

    assign bus.o_instruction = instr_q;
    assign bus.o_load_ready  = load_ready;
    assign bus.o_cpu_en      = cpu_en;
    assign bus.o_words       = wptr_q;

endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 NB_ADDR, 11, instruction address width; depth is 2**NB_ADDR words.
REQ-002 RAM_WIDTH, 16, instruction word width; the opcode is bits [RAM_WIDTH-1 -: 5].
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-low.
REQ-005 i_addr  input  NB_ADDR  fetch address from the CPU.
REQ-006 o_instruction  output  RAM_WIDTH  registered fetch data.
REQ-007 i_load_valid  input  1  loader byte strobe.
REQ-008 i_load_byte  input  8  loader byte; the high byte of each word arrives first.
REQ-009 o_load_ready  output  1  block accepts a loader byte this cycle.
REQ-010 i_reload  input  1  request to restart loading from address 0.
REQ-011 o_cpu_en  output  1  memory holds a valid program and the CPU may run.
REQ-012 o_words  output  NB_ADDR+1  number of words written in the last or current load.
REQ-013 o_checksum  output  8  modulo-256 sum of loaded bytes (see REQ-031).

Function
REQ-014 The block SHALL implement three states: LOAD_HI, LOAD_LO and RUN.
REQ-015 LOAD_HI: o_load_ready=1; a byte taken while i_load_valid=1 SHALL be latched as the high byte, then the state SHALL move to LOAD_LO.
REQ-016 LOAD_LO: o_load_ready=1; a byte taken while i_load_valid=1 SHALL be combined with the latched high byte into one word.
REQ-017 That word SHALL be written at the write pointer, the pointer SHALL increment, and o_words SHALL increment, all on the same edge.
REQ-018 After a LOAD_LO write, the state SHALL move to RUN if the word's opcode is 0 (HALT) or the written address was 2**NB_ADDR-1; otherwise it SHALL return to LOAD_HI.
REQ-019 Without i_load_valid, the state and write pointer SHALL hold.
REQ-020 RUN: o_load_ready=0 and o_cpu_en=1; loader strobes SHALL be ignored.
REQ-021 Fetch in RUN: o_instruction SHALL equal mem[i_addr] exactly one cycle after i_addr is presented (1-cycle read latency).
REQ-022 Fetch in load states: o_instruction SHALL be 0 (HALT) regardless of i_addr.
REQ-023 i_reload=1 in RUN SHALL, on the next edge, enter LOAD_HI and clear the write pointer, o_words and o_checksum.
REQ-024 When i_reload=1 in RUN, o_cpu_en SHALL fall on that same edge.
REQ-025 i_reload in LOAD_HI or LOAD_LO SHALL be ignored.
REQ-026 If i_reload and i_load_valid are both high in RUN, i_reload SHALL win and the byte SHALL be dropped.
REQ-027 Memory contents beyond the last written word SHALL keep their previous values; reload and reset SHALL NOT clear memory.
REQ-028 o_words SHALL saturate at 2**NB_ADDR; the write pointer SHALL never wrap inside one load.

Reset
REQ-029 While i_rst=0 at a clock edge, the block SHALL enter LOAD_HI.
REQ-030 Reset values SHALL be: o_instruction=0, o_load_ready=1, o_cpu_en=0, o_words=0, o_checksum=0, write pointer=0 and high-byte latch=0; a reset during LOAD_LO SHALL discard the pending high byte.

Configuration
REQ-031 With PM_CHECKSUM_EN defined, o_checksum SHALL add each accepted loader byte modulo 256 on its acceptance edge and hold in RUN.
REQ-032 Without PM_CHECKSUM_EN, o_checksum SHALL be constant 0 and no accumulator logic SHALL be present.

Verification
REQ-033 Reset, then bytes 0x08,0x05,0x10,0x03,0x00,0x00 -> o_words=3, o_cpu_en=1 after the 6th byte; fetching addresses 0,1,2 returns 0x0805, 0x1003, 0x0000 one cycle later; o_checksum=0x20 with the macro, 0 without.
REQ-034 During load, i_addr=0 -> o_instruction=0 every cycle; o_load_ready stays 1 across gaps in i_load_valid.
REQ-035 Load 2048 words with no HALT opcode -> RUN after the 4096th byte, o_words=2048; address 2047 reads the last word.
REQ-036 In RUN, i_reload=1 together with i_load_valid=1 -> next cycle LOAD_HI, o_cpu_en=0, o_words=0, and the byte is not counted.
REQ-037 i_rst=0 asserted after one byte in LOAD_LO, then reload 0x08,0x01,0x00,0x00 -> address 0 holds 0x0801, not a word built from the stale high byte.
